// File: rtl/tt_vpu_ovi_sb_ctrl.sv
// VPU-side OVI scoreboard/sequencing controller: tracks sb_ids from issue to completion,
// releases senior instructions in order and returns issue credits. Checker macro: TT_VPU_OVI_SB_CHECK_EN.
module tt_vpu_ovi_sb_ctrl #(
  parameter int NUM_SB = 32,
  parameter int QDEPTH = 16,
  parameter int SBW    = $clog2(NUM_SB),
  parameter int CNTW   = $clog2(QDEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           issue_valid,
  input  logic [SBW-1:0] issue_sb_id,
  input  logic           dispatch_next_senior,
  input  logic           dispatch_kill,
  input  logic [SBW-1:0] dispatch_sb_id,
  output logic           exec_valid,
  output logic [SBW-1:0] exec_sb_id,
  input  logic           exec_ready,
  input  logic           done_valid,
  input  logic [SBW-1:0] done_sb_id,
  output logic           completed_valid,
  output logic [SBW-1:0] completed_sb_id,
  output logic           issue_credit,
  output logic           busy,
  output logic           err_protocol
);

  localparam int PTRW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int OW   = CNTW + 1;

  typedef enum logic [1:0] {SLOT_FREE, SLOT_PEND, SLOT_SENIOR, SLOT_EXEC} slot_e;
  typedef enum logic {ST_INIT, ST_RUN} top_e;

  top_e            state_q;
  logic [CNTW-1:0] init_cnt_q;
  slot_e           slot_q   [NUM_SB];
  logic            killed_q [NUM_SB];
  logic [SBW-1:0]  fifo_q   [QDEPTH];
  logic [PTRW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] occ_q, occ_d;
  logic [CNTW-1:0] owed_q, owed_d;
  logic            exec_valid_q;
  logic [SBW-1:0]  exec_sb_id_q;
  logic            completed_valid_q;
  logic [SBW-1:0]  completed_sb_id_q;
  logic            issue_credit_q, issue_credit_d;
  logic            busy_q;

  logic            run, full, head_vld;
  logic [SBW-1:0]  head_id;
  slot_e           head_st, issue_st, disp_st, done_st;
  logic            issue_ok, disp_any, disp_both, disp_ok, done_ok;
  logic            pop_exec, pop_kill, present, pop;
  logic [OW-1:0]   owed_nx;
  logic            owed_ovf;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    run       = (state_q == ST_RUN);
    full      = (occ_q == CNTW'(QDEPTH));
    head_vld  = (occ_q != '0);
    head_id   = fifo_q[rd_ptr_q];
    head_st   = slot_q[head_id];
    issue_st  = slot_q[issue_sb_id];
    issue_ok  = issue_valid && (issue_st == SLOT_FREE) && !full;
    // A dispatch to the id being issued this cycle acts on the fresh PEND slot.
    disp_st   = (issue_ok && (issue_sb_id == dispatch_sb_id)) ? SLOT_PEND : slot_q[dispatch_sb_id];
    disp_any  = dispatch_next_senior || dispatch_kill;
    disp_both = dispatch_next_senior && dispatch_kill;
    disp_ok   = disp_any && !disp_both && ((disp_st == SLOT_PEND) || (disp_st == SLOT_SENIOR));
    done_st   = slot_q[done_sb_id];
    done_ok   = done_valid && (done_st == SLOT_EXEC);

    pop_exec  = exec_valid_q && exec_ready;
    pop_kill  = run && !exec_valid_q && head_vld && killed_q[head_id];
    present   = run && !exec_valid_q && head_vld && !killed_q[head_id] && (head_st == SLOT_SENIOR);
    pop       = pop_exec || pop_kill;

    issue_credit_d = run ? (owed_q != '0) : 1'b1;
    owed_nx  = {1'b0, owed_q} + OW'(pop_kill) + OW'(done_ok) - OW'(run && issue_credit_d);
    owed_ovf = (owed_nx > OW'(QDEPTH));
    owed_d   = owed_ovf ? CNTW'(QDEPTH) : owed_nx[CNTW-1:0];
    occ_d    = occ_q + CNTW'(issue_ok) - CNTW'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments; for same-index slot writes the last one wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= ST_INIT;
      init_cnt_q        <= '0;
      // NOTE: slot and FIFO arrays are reset too, so a mid-run reset discards all in-flight state.
      for (int i = 0; i < NUM_SB; i++) begin
        slot_q[i]   <= SLOT_FREE;
        killed_q[i] <= 1'b0;
      end
      for (int i = 0; i < QDEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      occ_q             <= '0;
      owed_q            <= '0;
      exec_valid_q      <= 1'b0;
      exec_sb_id_q      <= '0;
      completed_valid_q <= 1'b0;
      completed_sb_id_q <= '0;
      issue_credit_q    <= 1'b0;
      busy_q            <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == CNTW'(QDEPTH - 1)) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase

      issue_credit_q <= issue_credit_d;
      busy_q         <= head_vld || (owed_q != '0) || !run;
      owed_q         <= owed_d;
      occ_q          <= occ_d;

      if (issue_ok) begin
        slot_q[issue_sb_id] <= SLOT_PEND;
        fifo_q[wr_ptr_q]    <= issue_sb_id;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end

      if (disp_ok) begin
        if (dispatch_next_senior) slot_q[dispatch_sb_id] <= SLOT_SENIOR;
        else                      killed_q[dispatch_sb_id] <= 1'b1;
      end

      // Release: the presented head stays stable until accepted; a killed head drains silently.
      if (pop_exec) begin
        slot_q[exec_sb_id_q] <= SLOT_EXEC;
        exec_valid_q         <= 1'b0;
      end else if (present) begin
        exec_valid_q <= 1'b1;
        exec_sb_id_q <= head_id;
      end
      if (pop_kill) begin
        slot_q[head_id]   <= SLOT_FREE;
        killed_q[head_id] <= 1'b0;
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);

      completed_valid_q <= done_ok;
      if (done_ok) begin
        completed_sb_id_q    <= done_sb_id;
        slot_q[done_sb_id]   <= SLOT_FREE;
        killed_q[done_sb_id] <= 1'b0;
      end
    end
  end

  assign exec_valid      = exec_valid_q;
  assign exec_sb_id      = exec_sb_id_q;
  assign completed_valid = completed_valid_q;
  assign completed_sb_id = completed_sb_id_q;
  assign issue_credit    = issue_credit_q;
  assign busy            = busy_q;

`ifdef TT_VPU_OVI_SB_CHECK_EN
  logic err_q, err_evt;

  always_comb begin
    err_evt = (issue_valid && ((issue_st != SLOT_FREE) || full))
           || (disp_any && (disp_both || !((disp_st == SLOT_PEND) || (disp_st == SLOT_SENIOR))))
           || (done_valid && (done_st != SLOT_EXEC))
           || owed_ovf;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_q | err_evt;
  end

  assign err_protocol = err_q;
`else
  assign err_protocol = 1'b0;
`endif

endmodule
